// File: rtl/multi_port_pop_fifo.sv
// Multi-port in-order issue buffer: up to IN_PORTS pushes per cycle into a ring, oldest OUT_PORTS
// entries exposed as a consumer window. Optional high-water mark via MULTI_PORT_POP_FIFO_HWM_EN.
module multi_port_pop_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int IN_PORTS   = 2,
    parameter int OUT_PORTS  = 2,
    parameter int IN_ORDER   = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [IN_PORTS-1:0]              in_valid,
    input  logic [IN_PORTS*DATA_WIDTH-1:0]   in_data,
    output logic [IN_PORTS-1:0]              in_ready,
    output logic [OUT_PORTS-1:0]             out_valid,
    output logic [OUT_PORTS*DATA_WIDTH-1:0]  out_data,
    input  logic [OUT_PORTS-1:0]             out_ready,
`ifdef MULTI_PORT_POP_FIFO_HWM_EN
    input  logic                             hwm_clear,
    output logic [$clog2(DEPTH+1)-1:0]       hwm,
`endif
    output logic [$clog2(DEPTH+1)-1:0]       count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Handshake: a port transfers when valid & ready are both high at the rising edge. Pushes are
    // accepted as the leading run of ready&valid from port 0; slot j is taken when out_valid[j] &
    // out_ready[j]. With IN_ORDER=1 out_valid depends on out_ready combinationally.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         head;
    logic [PW-1:0]         tail;
    logic [OUT_PORTS-1:0]  done;

    logic [OUT_PORTS-1:0]  live;
    logic [OUT_PORTS-1:0]  take;
    logic [OUT_PORTS-1:0]  nd;
    logic [PW-1:0]         rd_idx;
    logic [CW-1:0]         count_next;
    logic                  run;
    logic                  blocked;
    int                    push_cnt;
    int                    pop_cnt;

    always_comb begin
        push_cnt = 0;
        run      = 1'b1;
        for (int i = 0; i < IN_PORTS; i++) begin
            in_ready[i] = ~flush && ((DEPTH - int'(count)) > i);
            if (run && in_valid[i] && in_ready[i]) push_cnt = push_cnt + 1;
            else run = 1'b0;
        end

        blocked  = 1'b0;
        rd_idx   = '0;
        out_data = '0;
        for (int j = 0; j < OUT_PORTS; j++) begin
            live[j]      = (int'(count) > j) && !done[j];
            out_valid[j] = ~flush && live[j] && !((IN_ORDER != 0) && blocked);
            if (live[j] && !out_ready[j]) blocked = 1'b1;
            rd_idx = head + PW'(j);
            out_data[j*DATA_WIDTH +: DATA_WIDTH] = mem[rd_idx];
        end

        take = out_valid & out_ready;
        nd   = done | take;

        // Only the contiguous consumed prefix retires; later consumed slots wait in done.
        pop_cnt = 0;
        run     = 1'b1;
        for (int j = 0; j < OUT_PORTS; j++) begin
            if (run && nd[j] && (int'(count) > j)) pop_cnt = pop_cnt + 1;
            else run = 1'b0;
        end

        count_next = flush ? '0 : CW'(int'(count) + push_cnt - pop_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            done  <= '0;
        end else begin
            head  <= head + PW'(pop_cnt);
            tail  <= tail + PW'(push_cnt);
            count <= count_next;
            done  <= nd >> pop_cnt;
        end
    end

    // Payload storage carries no reset; push_cnt is already zero during flush.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < IN_PORTS; i++) begin
                if (i < push_cnt) mem[tail + PW'(i)] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef MULTI_PORT_POP_FIFO_HWM_EN
    // Flush empties the buffer but keeps the recorded peak.
    always_ff @(posedge clk) begin
        if (rst || hwm_clear) hwm <= '0;
        else if (count_next > hwm) hwm <= count_next;
    end
`endif

endmodule
